arp_cam_requester: RTL

ARP_CAM_REQUESTER -- requirements
Module: arp_cam_requester

---
 rtl/arp_cam_requester.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/arp_cam_requester.sv
// rtl/arp_cam_requester.sv - host lookup/update front-end for the ARP CAM, two independent channel FSMs
// Optional: define ARP_CAM_REQUESTER_KEYCHK_EN to drop mismatched-key responses and add KeyErrCnt.
module arp_cam_requester #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        InitDone,
   input  logic        HostLkpReqValid,
   output logic        HostLkpReqReady,
   input  logic [31:0] HostLkpReqKey,
   output logic        HostLkpRspValid,
   input  logic        HostLkpRspReady,
   output logic        HostLkpRspHit,
   output logic        HostLkpRspTmo,
   output logic [47:0] HostLkpRspMac,
   input  logic        HostUpdReqValid,
   output logic        HostUpdReqReady,
   input  logic        HostUpdOp,
   input  logic [31:0] HostUpdKey,
   input  logic        HostUpdStatic,
   input  logic [47:0] HostUpdValue,
   output logic        HostUpdDone,
   output logic        HostUpdErr,
   output logic        LookupReqValid,
   output logic [31:0] LookupReqKey,
   input  logic        LookupRespValid,
   input  logic        LookupRespHit,
   input  logic [31:0] LookupRespKey,
   input  logic [47:0] LookupRespValue,
   output logic        UpdateValid,
   output logic        UpdateOp,
   output logic [31:0] UpdateKey,
   output logic        UpdateStatic,
   output logic [47:0] UpdateValue,
   input  logic        UpdateAck,
`ifdef ARP_CAM_REQUESTER_KEYCHK_EN
   output logic [15:0] KeyErrCnt,
`endif
   output logic [15:0] HitCnt,
   output logic [15:0] MissCnt
);

   // Timer counts cycles already spent waiting; expiry is the last allowed cycle.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {L_IDLE, L_REQ, L_WAIT, L_RSP} lkpState_t;
   typedef enum logic [1:0] {U_IDLE, U_REQ, U_DONE} updState_t;

   lkpState_t   lkpState, lkpNext;
   updState_t   updState, updNext;
   logic [7:0]  lkpTimer, updTimer;
   logic [31:0] lkpKey;
   logic        rspHit, rspTmo;
   logic [47:0] rspMac;
   logic [15:0] hitCntQ, missCntQ;
   logic        updOpQ, updStaticQ, updErrQ;
   logic [31:0] updKeyQ;
   logic [47:0] updValueQ;
   logic        lkpAccept, updAccept, respTake, lkpExpire, updExpire;

   assign lkpAccept = (lkpState == L_IDLE) && InitDone && HostLkpReqValid;
   assign updAccept = (updState == U_IDLE) && InitDone && HostUpdReqValid;
   assign lkpExpire = (lkpState == L_WAIT) && (lkpTimer == TMO_LAST);
   assign updExpire = (updState == U_REQ) && (updTimer == TMO_LAST);

`ifdef ARP_CAM_REQUESTER_KEYCHK_EN
   logic        respKeyBad;
   logic [15:0] keyErrCntQ;
   assign respTake   = (lkpState == L_WAIT) && LookupRespValid && (LookupRespKey == lkpKey);
   assign respKeyBad = (lkpState == L_WAIT) && LookupRespValid && (LookupRespKey != lkpKey);
`else
   logic unusedRespKey;
   assign unusedRespKey = ^LookupRespKey;
   assign respTake      = (lkpState == L_WAIT) && LookupRespValid;
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         lkpState <= L_IDLE;
         updState <= U_IDLE;
      end else begin
         lkpState <= lkpNext;
         updState <= updNext;
      end
   end

   always_comb begin
      lkpNext = lkpState;
      case (lkpState)
         L_IDLE:  if (lkpAccept) lkpNext = L_REQ;
         L_REQ:   lkpNext = L_WAIT;
         L_WAIT:  if (respTake || lkpExpire) lkpNext = L_RSP;
         L_RSP:   if (HostLkpRspReady) lkpNext = L_IDLE;
         default: lkpNext = L_IDLE;
      endcase
      updNext = updState;
      case (updState)
         U_IDLE:  if (updAccept) updNext = U_REQ;
         U_REQ:   if (UpdateAck || updExpire) updNext = U_DONE;
         U_DONE:  updNext = U_IDLE;
         default: updNext = U_IDLE;
      endcase
   end

   // Every output is forced low while Rst is asserted, even before the state register clears.
   always_comb begin
      HostLkpReqReady = 1'b0;
      LookupReqValid  = 1'b0;
      LookupReqKey    = '0;
      HostLkpRspValid = 1'b0;
      HostLkpRspHit   = 1'b0;
      HostLkpRspTmo   = 1'b0;
      HostLkpRspMac   = '0;
      HostUpdReqReady = 1'b0;
      UpdateValid     = 1'b0;
      UpdateOp        = 1'b0;
      UpdateKey       = '0;
      UpdateStatic    = 1'b0;
      UpdateValue     = '0;
      HostUpdDone     = 1'b0;
      HostUpdErr      = 1'b0;
      HitCnt          = '0;
      MissCnt         = '0;
`ifdef ARP_CAM_REQUESTER_KEYCHK_EN
      KeyErrCnt       = '0;
`endif
      if (!Rst) begin
         HostLkpReqReady = (lkpState == L_IDLE) && InitDone;
         HostUpdReqReady = (updState == U_IDLE) && InitDone;
         if (lkpState == L_REQ) begin
            LookupReqValid = 1'b1;
            LookupReqKey   = lkpKey;
         end
         if (lkpState == L_RSP) begin
            HostLkpRspValid = 1'b1;
            HostLkpRspHit   = rspHit;
            HostLkpRspTmo   = rspTmo;
            HostLkpRspMac   = rspMac;
         end
         if (updState == U_REQ) begin
            UpdateValid  = 1'b1;
            UpdateOp     = updOpQ;
            UpdateKey    = updKeyQ;
            UpdateStatic = updStaticQ;
            UpdateValue  = updValueQ;
         end
         if (updState == U_DONE) begin
            HostUpdDone = 1'b1;
            HostUpdErr  = updErrQ;
         end
         HitCnt  = hitCntQ;
         MissCnt = missCntQ;
`ifdef ARP_CAM_REQUESTER_KEYCHK_EN
         KeyErrCnt = keyErrCntQ;
`endif
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         lkpTimer   <= '0;
         updTimer   <= '0;
         lkpKey     <= '0;
         rspHit     <= 1'b0;
         rspTmo     <= 1'b0;
         rspMac     <= '0;
         hitCntQ    <= '0;
         missCntQ   <= '0;
         updOpQ     <= 1'b0;
         updKeyQ    <= '0;
         updStaticQ <= 1'b0;
         updValueQ  <= '0;
         updErrQ    <= 1'b0;
`ifdef ARP_CAM_REQUESTER_KEYCHK_EN
         keyErrCntQ <= '0;
`endif
      end else begin
         if (lkpAccept) lkpKey <= HostLkpReqKey;
         if (lkpState == L_REQ) lkpTimer <= '0;
         else if (lkpState == L_WAIT && lkpTimer != 8'hFF) lkpTimer <= lkpTimer + 8'd1;

         // A response in the expiry cycle takes priority over the timeout.
         if (respTake) begin
            rspHit <= LookupRespHit;
            rspTmo <= 1'b0;
            rspMac <= LookupRespHit ? LookupRespValue : '0;
            if (LookupRespHit) begin
               if (hitCntQ != 16'hFFFF) hitCntQ <= hitCntQ + 16'd1;
            end else if (missCntQ != 16'hFFFF) begin
               missCntQ <= missCntQ + 16'd1;
            end
         end else if (lkpExpire) begin
            rspHit <= 1'b0;
            rspTmo <= 1'b1;
            rspMac <= '0;
            if (missCntQ != 16'hFFFF) missCntQ <= missCntQ + 16'd1;
         end
`ifdef ARP_CAM_REQUESTER_KEYCHK_EN
         if (respKeyBad && keyErrCntQ != 16'hFFFF) keyErrCntQ <= keyErrCntQ + 16'd1;
`endif

         if (updAccept) begin
            updOpQ     <= HostUpdOp;
            updKeyQ    <= HostUpdKey;
            updStaticQ <= HostUpdStatic;
            updValueQ  <= HostUpdValue;
            updTimer   <= '0;
         end else if (updState == U_REQ && updTimer != 8'hFF) begin
            updTimer <= updTimer + 8'd1;
         end
         if (updState == U_REQ) begin
            if (UpdateAck) updErrQ <= 1'b0;
            else if (updExpire) updErrQ <= 1'b1;
         end
      end
   end

endmodule
